axi_exclusive_monitor: RTL and testbench

//  AXI4 exclusive-access monitor placed between a CPU AXI4 master and a memory slave
//  (for example armleocpu_axi_bram). All channels are forwarded between the two sides.
//  It keeps one reservation: a locked read sets it; a locked write to the reserved

---
 rtl/axi_exclusive_monitor.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_exclusive_monitor.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_exclusive_monitor.sv
// axi_exclusive_monitor
//   Sits between a CPU AXI4 master and a memory AXI4 slave and forwards all
//   five channels with no added latency. It tracks a single exclusive
//   reservation so that LR/SC sequences can be built from AXI locked accesses:
//     - a locked single-beat read sets the reservation to its address and
//       reports EXOKAY instead of OKAY;
//     - a locked single-beat write to the reserved address goes through and
//       reports EXOKAY;
//     - any other locked write is sent to memory with WSTRB=0 (a no-op) and
//       reports whatever memory returns (OKAY for a good address).
//   Any write whose address equals the reservation clears it.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cpu_axi_*           slave-side port facing the CPU (with AWLOCK/ARLOCK)
//   memory_axi_*        master-side port facing memory (no lock signals)
//
// Handshake rules: a transfer happens on a rising edge where VALID and READY
// of the channel are both high. VALID and READY pass straight through, except
// that AW/AR are held off (valid and ready both forced low) while a previous
// write/read of the same direction is outstanding, and W is held off until
// its AW has been accepted. Only one write and one read are in flight at once.
module axi_exclusive_monitor #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    cpu_axi_awvalid,
    input  logic [ADDR_WIDTH-1:0]   cpu_axi_awaddr,
    input  logic [7:0]              cpu_axi_awlen,
    input  logic [2:0]              cpu_axi_awsize,
    input  logic [1:0]              cpu_axi_awburst,
    input  logic [ID_WIDTH-1:0]     cpu_axi_awid,
    input  logic                    cpu_axi_awlock,
    output logic                    cpu_axi_awready,

    input  logic                    cpu_axi_wvalid,
    input  logic [DATA_WIDTH-1:0]   cpu_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_axi_wstrb,
    input  logic                    cpu_axi_wlast,
    output logic                    cpu_axi_wready,

    output logic                    cpu_axi_bvalid,
    output logic [1:0]              cpu_axi_bresp,
    output logic [ID_WIDTH-1:0]     cpu_axi_bid,
    input  logic                    cpu_axi_bready,

    input  logic                    cpu_axi_arvalid,
    input  logic [ADDR_WIDTH-1:0]   cpu_axi_araddr,
    input  logic [7:0]              cpu_axi_arlen,
    input  logic [2:0]              cpu_axi_arsize,
    input  logic [1:0]              cpu_axi_arburst,
    input  logic [ID_WIDTH-1:0]     cpu_axi_arid,
    input  logic                    cpu_axi_arlock,
    output logic                    cpu_axi_arready,

    output logic                    cpu_axi_rvalid,
    output logic [1:0]              cpu_axi_rresp,
    output logic [DATA_WIDTH-1:0]   cpu_axi_rdata,
    output logic [ID_WIDTH-1:0]     cpu_axi_rid,
    output logic                    cpu_axi_rlast,
    input  logic                    cpu_axi_rready,

    output logic                    memory_axi_awvalid,
    output logic [ADDR_WIDTH-1:0]   memory_axi_awaddr,
    output logic [7:0]              memory_axi_awlen,
    output logic [2:0]              memory_axi_awsize,
    output logic [1:0]              memory_axi_awburst,
    output logic [ID_WIDTH-1:0]     memory_axi_awid,
    input  logic                    memory_axi_awready,

    output logic                    memory_axi_wvalid,
    output logic [DATA_WIDTH-1:0]   memory_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] memory_axi_wstrb,
    output logic                    memory_axi_wlast,
    input  logic                    memory_axi_wready,

    input  logic                    memory_axi_bvalid,
    input  logic [1:0]              memory_axi_bresp,
    input  logic [ID_WIDTH-1:0]     memory_axi_bid,
    output logic                    memory_axi_bready,

    output logic                    memory_axi_arvalid,
    output logic [ADDR_WIDTH-1:0]   memory_axi_araddr,
    output logic [7:0]              memory_axi_arlen,
    output logic [2:0]              memory_axi_arsize,
    output logic [1:0]              memory_axi_arburst,
    output logic [ID_WIDTH-1:0]     memory_axi_arid,
    input  logic                    memory_axi_arready,

    input  logic                    memory_axi_rvalid,
    input  logic [1:0]              memory_axi_rresp,
    input  logic [DATA_WIDTH-1:0]   memory_axi_rdata,
    input  logic [ID_WIDTH-1:0]     memory_axi_rid,
    input  logic                    memory_axi_rlast,
    output logic                    memory_axi_rready
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;

    logic                  res_valid_q,   res_valid_d;
    logic [ADDR_WIDTH-1:0] res_addr_q,    res_addr_d;
    logic                  wr_busy_q,     wr_busy_d;
    logic                  rd_busy_q,     rd_busy_d;
    logic                  wr_excl_ok_q,  wr_excl_ok_d;
    logic                  wr_suppress_q, wr_suppress_d;
    logic                  rd_excl_q,     rd_excl_d;

    logic aw_hs, b_hs, ar_hs, r_last_hs;
    logic aw_hits_res;
    logic aw_excl_ok;

    // Address/control fields pass straight through.
    assign memory_axi_awaddr  = cpu_axi_awaddr;
    assign memory_axi_awlen   = cpu_axi_awlen;
    assign memory_axi_awsize  = cpu_axi_awsize;
    assign memory_axi_awburst = cpu_axi_awburst;
    assign memory_axi_awid    = cpu_axi_awid;
    assign memory_axi_araddr  = cpu_axi_araddr;
    assign memory_axi_arlen   = cpu_axi_arlen;
    assign memory_axi_arsize  = cpu_axi_arsize;
    assign memory_axi_arburst = cpu_axi_arburst;
    assign memory_axi_arid    = cpu_axi_arid;
    assign memory_axi_wdata   = cpu_axi_wdata;
    assign memory_axi_wlast   = cpu_axi_wlast;

    // AW/AR are blocked while one of the same direction is outstanding.
    assign memory_axi_awvalid = cpu_axi_awvalid & ~wr_busy_q;
    assign cpu_axi_awready    = memory_axi_awready & ~wr_busy_q;
    assign memory_axi_arvalid = cpu_axi_arvalid & ~rd_busy_q;
    assign cpu_axi_arready    = memory_axi_arready & ~rd_busy_q;

    // W only flows once its AW has been accepted; a failed exclusive is
    // turned into a write with no byte lanes enabled.
    assign memory_axi_wvalid  = cpu_axi_wvalid & wr_busy_q;
    assign cpu_axi_wready     = memory_axi_wready & wr_busy_q;
    assign memory_axi_wstrb   = wr_suppress_q ? '0 : cpu_axi_wstrb;

    // Responses: OKAY is upgraded to EXOKAY only for a successful exclusive;
    // error responses from memory always pass through untouched.
    assign cpu_axi_bvalid     = memory_axi_bvalid;
    assign cpu_axi_bid        = memory_axi_bid;
    assign cpu_axi_bresp      = (wr_excl_ok_q && memory_axi_bresp == RESP_OKAY)
                                ? RESP_EXOKAY : memory_axi_bresp;
    assign memory_axi_bready  = cpu_axi_bready;

    assign cpu_axi_rvalid     = memory_axi_rvalid;
    assign cpu_axi_rdata      = memory_axi_rdata;
    assign cpu_axi_rid        = memory_axi_rid;
    assign cpu_axi_rlast      = memory_axi_rlast;
    assign cpu_axi_rresp      = (rd_excl_q && memory_axi_rresp == RESP_OKAY)
                                ? RESP_EXOKAY : memory_axi_rresp;
    assign memory_axi_rready  = cpu_axi_rready;

    assign aw_hs     = cpu_axi_awvalid & cpu_axi_awready;
    assign b_hs      = memory_axi_bvalid & cpu_axi_bready;
    assign ar_hs     = cpu_axi_arvalid & cpu_axi_arready;
    assign r_last_hs = memory_axi_rvalid & cpu_axi_rready & memory_axi_rlast;

    // The write check always looks at the reservation as it stood before
    // this cycle, even if a read is updating it at the same edge.
    assign aw_hits_res = res_valid_q & (res_addr_q == cpu_axi_awaddr);
    assign aw_excl_ok  = cpu_axi_awlock & (cpu_axi_awlen == 8'd0) & aw_hits_res;

    always_comb begin
        res_valid_d   = res_valid_q;
        res_addr_d    = res_addr_q;
        wr_busy_d     = wr_busy_q;
        rd_busy_d     = rd_busy_q;
        wr_excl_ok_d  = wr_excl_ok_q;
        wr_suppress_d = wr_suppress_q;
        rd_excl_d     = rd_excl_q;

        if (b_hs) begin
            wr_busy_d = 1'b0;
        end
        if (aw_hs) begin
            wr_busy_d     = 1'b1;
            wr_excl_ok_d  = aw_excl_ok;
            wr_suppress_d = cpu_axi_awlock & ~aw_excl_ok;
            if (aw_hits_res) begin
                res_valid_d = 1'b0;
            end
        end

        if (r_last_hs) begin
            rd_busy_d = 1'b0;
        end
        // Placed after the write update so a same-cycle exclusive read wins.
        if (ar_hs) begin
            rd_busy_d = 1'b1;
            rd_excl_d = cpu_axi_arlock & (cpu_axi_arlen == 8'd0);
            if (cpu_axi_arlock && cpu_axi_arlen == 8'd0) begin
                res_valid_d = 1'b1;
                res_addr_d  = cpu_axi_araddr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q   <= 1'b0;
            res_addr_q    <= '0;
            wr_busy_q     <= 1'b0;
            rd_busy_q     <= 1'b0;
            wr_excl_ok_q  <= 1'b0;
            wr_suppress_q <= 1'b0;
            rd_excl_q     <= 1'b0;
        end else begin
            res_valid_q   <= res_valid_d;
            res_addr_q    <= res_addr_d;
            wr_busy_q     <= wr_busy_d;
            rd_busy_q     <= rd_busy_d;
            wr_excl_ok_q  <= wr_excl_ok_d;
            wr_suppress_q <= wr_suppress_d;
            rd_excl_q     <= rd_excl_d;
        end
    end

endmodule

// File: tb/tb_axi_exclusive_monitor.sv
// Bench for axi_exclusive_monitor: a small AXI4 memory slave (10 words,
// SLVERR outside that range) sits on the memory port, and the CPU side is
// driven by read/write tasks. Expected responses are queued when a request
// is issued and compared when the response handshake happens.
module tb_axi_exclusive_monitor;

    localparam int W = 39;   // {last, resp, id, data}

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cpu_axi_awvalid = 0, cpu_axi_awlock = 0, cpu_axi_awready;
    logic [31:0] cpu_axi_awaddr = 0;
    logic [7:0]  cpu_axi_awlen = 0;
    logic [2:0]  cpu_axi_awsize = 3'd2;
    logic [1:0]  cpu_axi_awburst = 2'b01;
    logic [3:0]  cpu_axi_awid = 0;
    logic        cpu_axi_wvalid = 0, cpu_axi_wlast = 0, cpu_axi_wready;
    logic [31:0] cpu_axi_wdata = 0;
    logic [3:0]  cpu_axi_wstrb = 0;
    logic        cpu_axi_bvalid, cpu_axi_bready = 0;
    logic [1:0]  cpu_axi_bresp;
    logic [3:0]  cpu_axi_bid;
    logic        cpu_axi_arvalid = 0, cpu_axi_arlock = 0, cpu_axi_arready;
    logic [31:0] cpu_axi_araddr = 0;
    logic [7:0]  cpu_axi_arlen = 0;
    logic [2:0]  cpu_axi_arsize = 3'd2;
    logic [1:0]  cpu_axi_arburst = 2'b01;
    logic [3:0]  cpu_axi_arid = 0;
    logic        cpu_axi_rvalid, cpu_axi_rlast, cpu_axi_rready = 0;
    logic [1:0]  cpu_axi_rresp;
    logic [31:0] cpu_axi_rdata;
    logic [3:0]  cpu_axi_rid;

    logic        memory_axi_awvalid, memory_axi_awready;
    logic [31:0] memory_axi_awaddr;
    logic [7:0]  memory_axi_awlen;
    logic [2:0]  memory_axi_awsize;
    logic [1:0]  memory_axi_awburst;
    logic [3:0]  memory_axi_awid;
    logic        memory_axi_wvalid, memory_axi_wlast, memory_axi_wready;
    logic [31:0] memory_axi_wdata;
    logic [3:0]  memory_axi_wstrb;
    logic        memory_axi_bvalid, memory_axi_bready;
    logic [1:0]  memory_axi_bresp;
    logic [3:0]  memory_axi_bid;
    logic        memory_axi_arvalid, memory_axi_arready;
    logic [31:0] memory_axi_araddr;
    logic [7:0]  memory_axi_arlen;
    logic [2:0]  memory_axi_arsize;
    logic [1:0]  memory_axi_arburst;
    logic [3:0]  memory_axi_arid;
    logic        memory_axi_rvalid, memory_axi_rlast, memory_axi_rready;
    logic [1:0]  memory_axi_rresp;
    logic [31:0] memory_axi_rdata;
    logic [3:0]  memory_axi_rid;

    axi_exclusive_monitor #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_axi_awvalid(cpu_axi_awvalid), .cpu_axi_awaddr(cpu_axi_awaddr),
        .cpu_axi_awlen(cpu_axi_awlen), .cpu_axi_awsize(cpu_axi_awsize),
        .cpu_axi_awburst(cpu_axi_awburst), .cpu_axi_awid(cpu_axi_awid),
        .cpu_axi_awlock(cpu_axi_awlock), .cpu_axi_awready(cpu_axi_awready),
        .cpu_axi_wvalid(cpu_axi_wvalid), .cpu_axi_wdata(cpu_axi_wdata),
        .cpu_axi_wstrb(cpu_axi_wstrb), .cpu_axi_wlast(cpu_axi_wlast),
        .cpu_axi_wready(cpu_axi_wready),
        .cpu_axi_bvalid(cpu_axi_bvalid), .cpu_axi_bresp(cpu_axi_bresp),
        .cpu_axi_bid(cpu_axi_bid), .cpu_axi_bready(cpu_axi_bready),
        .cpu_axi_arvalid(cpu_axi_arvalid), .cpu_axi_araddr(cpu_axi_araddr),
        .cpu_axi_arlen(cpu_axi_arlen), .cpu_axi_arsize(cpu_axi_arsize),
        .cpu_axi_arburst(cpu_axi_arburst), .cpu_axi_arid(cpu_axi_arid),
        .cpu_axi_arlock(cpu_axi_arlock), .cpu_axi_arready(cpu_axi_arready),
        .cpu_axi_rvalid(cpu_axi_rvalid), .cpu_axi_rresp(cpu_axi_rresp),
        .cpu_axi_rdata(cpu_axi_rdata), .cpu_axi_rid(cpu_axi_rid),
        .cpu_axi_rlast(cpu_axi_rlast), .cpu_axi_rready(cpu_axi_rready),
        .memory_axi_awvalid(memory_axi_awvalid), .memory_axi_awaddr(memory_axi_awaddr),
        .memory_axi_awlen(memory_axi_awlen), .memory_axi_awsize(memory_axi_awsize),
        .memory_axi_awburst(memory_axi_awburst), .memory_axi_awid(memory_axi_awid),
        .memory_axi_awready(memory_axi_awready),
        .memory_axi_wvalid(memory_axi_wvalid), .memory_axi_wdata(memory_axi_wdata),
        .memory_axi_wstrb(memory_axi_wstrb), .memory_axi_wlast(memory_axi_wlast),
        .memory_axi_wready(memory_axi_wready),
        .memory_axi_bvalid(memory_axi_bvalid), .memory_axi_bresp(memory_axi_bresp),
        .memory_axi_bid(memory_axi_bid), .memory_axi_bready(memory_axi_bready),
        .memory_axi_arvalid(memory_axi_arvalid), .memory_axi_araddr(memory_axi_araddr),
        .memory_axi_arlen(memory_axi_arlen), .memory_axi_arsize(memory_axi_arsize),
        .memory_axi_arburst(memory_axi_arburst), .memory_axi_arid(memory_axi_arid),
        .memory_axi_arready(memory_axi_arready),
        .memory_axi_rvalid(memory_axi_rvalid), .memory_axi_rresp(memory_axi_rresp),
        .memory_axi_rdata(memory_axi_rdata), .memory_axi_rid(memory_axi_rid),
        .memory_axi_rlast(memory_axi_rlast), .memory_axi_rready(memory_axi_rready)
    );

    // ---------------- memory slave model ----------------
    logic [31:0] smem [0:9];
    logic        s_aw_pend, s_b_pend, s_r_pend;
    logic [31:0] s_aw_addr, s_r_addr, s_r_data;
    logic [1:0]  s_bresp, s_rresp;
    logic [3:0]  s_bid, s_aw_id, s_rid;
    logic [7:0]  s_r_cnt;

    function automatic logic in_range(input logic [31:0] a);
        return a[31:2] < 30'd10;
    endfunction

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (in_range(a)) return smem[a[5:2]];
        return 32'h0;
    endfunction

    assign memory_axi_awready = !s_aw_pend;
    assign memory_axi_wready  = s_aw_pend && !s_b_pend;
    assign memory_axi_bvalid  = s_b_pend;
    assign memory_axi_bresp   = s_bresp;
    assign memory_axi_bid     = s_bid;
    assign memory_axi_arready = !s_r_pend;
    assign memory_axi_rvalid  = s_r_pend;
    assign memory_axi_rdata   = s_r_data;
    assign memory_axi_rresp   = s_rresp;
    assign memory_axi_rid     = s_rid;
    assign memory_axi_rlast   = (s_r_cnt == 8'd0);

    initial begin
        for (int i = 0; i < 10; i++) smem[i] = 32'hA000_0000 | i;
    end

    always @(posedge clk) begin
        if (rst_n && memory_axi_wvalid && memory_axi_wready && in_range(s_aw_addr)) begin
            for (int k = 0; k < 4; k++)
                if (memory_axi_wstrb[k]) smem[s_aw_addr[5:2]][8*k +: 8] <= memory_axi_wdata[8*k +: 8];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_aw_pend <= 0; s_b_pend <= 0; s_r_pend <= 0;
            s_aw_addr <= 0; s_aw_id <= 0; s_bid <= 0; s_bresp <= 0;
            s_r_addr <= 0; s_r_data <= 0; s_rresp <= 0; s_rid <= 0; s_r_cnt <= 0;
        end else begin
            if (memory_axi_awvalid && memory_axi_awready) begin
                s_aw_pend <= 1; s_aw_addr <= memory_axi_awaddr; s_aw_id <= memory_axi_awid;
            end
            if (memory_axi_wvalid && memory_axi_wready) begin
                s_aw_pend <= 0; s_b_pend <= 1; s_bid <= s_aw_id;
                s_bresp <= in_range(s_aw_addr) ? 2'b00 : 2'b10;
            end
            if (memory_axi_bvalid && memory_axi_bready) s_b_pend <= 0;
            if (memory_axi_arvalid && memory_axi_arready) begin
                s_r_pend <= 1; s_r_addr <= memory_axi_araddr; s_rid <= memory_axi_arid;
                s_r_cnt <= memory_axi_arlen; s_r_data <= rd_word(memory_axi_araddr);
                s_rresp <= in_range(memory_axi_araddr) ? 2'b00 : 2'b10;
            end
            if (memory_axi_rvalid && memory_axi_rready) begin
                if (s_r_cnt == 0) s_r_pend <= 0;
                else begin
                    s_r_cnt <= s_r_cnt - 1; s_r_addr <= s_r_addr + 4;
                    s_r_data <= rd_word(s_r_addr + 4);
                    s_rresp <= in_range(s_r_addr + 4) ? 2'b00 : 2'b10;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_r_q[$];
    logic [W-1:0] exp_b_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout/underflow expected response", name);
    endtask

    // ---------------- driver tasks (called at a falling edge) ----------------
    task automatic do_read(input logic [31:0] addr, input logic lock, input logic [7:0] len,
                           input logic [3:0] id, input logic [1:0] exp_resp,
                           input logic [31:0] exp_d0, input logic [31:0] exp_d1);
        int n;
        for (int b = 0; b <= int'(len); b++)
            exp_r_q.push_back({(b == int'(len)), exp_resp, id, (b == 0) ? exp_d0 : exp_d1});
        cpu_axi_arvalid = 1; cpu_axi_araddr = addr; cpu_axi_arlock = lock;
        cpu_axi_arlen = len; cpu_axi_arid = id;
        n = 0; #1;
        while (!cpu_axi_arready && n < 50) begin @(negedge clk); #1; n++; end
        if (!cpu_axi_arready) begin fail_now("ar_timeout"); cpu_axi_arvalid = 0; return; end
        @(negedge clk);
        cpu_axi_arvalid = 0; cpu_axi_arlock = 0;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0; #1;
            while (!cpu_axi_rvalid && n < 50) begin @(negedge clk); #1; n++; end
            if (!cpu_axi_rvalid) begin fail_now("r_timeout"); return; end
            @(negedge clk);
            cpu_axi_rready = 1; #1;
            if (exp_r_q.size() == 0) fail_now("r_underflow");
            else check("r_beat", {cpu_axi_rlast, cpu_axi_rresp, cpu_axi_rid, cpu_axi_rdata},
                       exp_r_q.pop_front());
            @(negedge clk);
            cpu_axi_rready = 0;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic lock, input logic [31:0] data,
                            input logic [3:0] strb, input logic [3:0] id,
                            input logic [1:0] exp_resp, input logic [3:0] exp_strb);
        int n;
        exp_b_q.push_back({{(W-6){1'b0}}, exp_resp, id});
        cpu_axi_awvalid = 1; cpu_axi_awaddr = addr; cpu_axi_awlock = lock;
        cpu_axi_awlen = 0; cpu_axi_awid = id;
        n = 0; #1;
        while (!cpu_axi_awready && n < 50) begin @(negedge clk); #1; n++; end
        if (!cpu_axi_awready) begin fail_now("aw_timeout"); cpu_axi_awvalid = 0; return; end
        @(negedge clk);
        cpu_axi_awvalid = 0; cpu_axi_awlock = 0;
        cpu_axi_wvalid = 1; cpu_axi_wdata = data; cpu_axi_wstrb = strb; cpu_axi_wlast = 1;
        n = 0; #1;
        while (!cpu_axi_wready && n < 50) begin @(negedge clk); #1; n++; end
        if (!cpu_axi_wready) begin fail_now("w_timeout"); cpu_axi_wvalid = 0; return; end
        check("mem_wvalid_wstrb", W'({memory_axi_wvalid, memory_axi_wstrb}), W'({1'b1, exp_strb}));
        check("mem_wdata", W'(memory_axi_wdata), W'(data));
        @(negedge clk);
        cpu_axi_wvalid = 0; cpu_axi_wlast = 0;
        n = 0; #1;
        while (!cpu_axi_bvalid && n < 50) begin @(negedge clk); #1; n++; end
        if (!cpu_axi_bvalid) begin fail_now("b_timeout"); return; end
        @(negedge clk);
        cpu_axi_bready = 1; #1;
        if (exp_b_q.size() == 0) fail_now("b_underflow");
        else check("b_resp", {{(W-6){1'b0}}, cpu_axi_bresp, cpu_axi_bid}, exp_b_q.pop_front());
        @(negedge clk);
        cpu_axi_bready = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wr;
        logic        lock;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  id;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_strb;
    } vec_t;

    vec_t vecs[18];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'h24, 32'h0,        4'h0, 4'h4, 2'b00, 32'hA000_0009, 4'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h20, 32'h0,        4'h0, 4'h1, 2'b01, 32'hA000_0008, 4'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h24, 32'hFFFF_FFFF, 4'hF, 4'h2, 2'b00, 32'h0,        4'hF};
        vecs[3]  = '{1'b0, 1'b0, 32'h24, 32'h0,        4'h0, 4'h3, 2'b00, 32'hFFFF_FFFF, 4'h0};
        vecs[4]  = '{1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 4'h5, 2'b01, 32'h0,        4'hF};
        vecs[5]  = '{1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, 4'h6, 2'b00, 32'h0,        4'h0};
        vecs[6]  = '{1'b0, 1'b0, 32'h20, 32'h0,        4'h0, 4'h7, 2'b00, 32'h1234_5678, 4'h0};
        vecs[7]  = '{1'b0, 1'b1, 32'h40, 32'h0,        4'h0, 4'h8, 2'b10, 32'h0,        4'h0};
        vecs[8]  = '{1'b1, 1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 4'h9, 2'b10, 32'h0,        4'hF};
        vecs[9]  = '{1'b1, 1'b0, 32'h28, 32'h1,        4'hF, 4'hA, 2'b10, 32'h0,        4'hF};
        vecs[10] = '{1'b0, 1'b1, 32'h10, 32'h0,        4'h0, 4'hB, 2'b01, 32'hA000_0004, 4'h0};
        vecs[11] = '{1'b1, 1'b0, 32'h10, 32'h55,       4'h1, 4'hC, 2'b00, 32'h0,        4'h1};
        vecs[12] = '{1'b1, 1'b1, 32'h10, 32'h0,        4'hF, 4'hD, 2'b00, 32'h0,        4'h0};
        vecs[13] = '{1'b0, 1'b0, 32'h10, 32'h0,        4'h0, 4'hE, 2'b00, 32'hA000_0055, 4'h0};
        vecs[14] = '{1'b0, 1'b1, 32'h0C, 32'h0,        4'h0, 4'hF, 2'b01, 32'hA000_0003, 4'h0};
        vecs[15] = '{1'b1, 1'b1, 32'h0D, 32'h9999_9999, 4'hF, 4'h0, 2'b00, 32'h0,        4'h0};
        vecs[16] = '{1'b1, 1'b1, 32'h0C, 32'h7777_7777, 4'h3, 4'h1, 2'b01, 32'h0,        4'h3};
        vecs[17] = '{1'b0, 1'b0, 32'h0C, 32'h0,        4'h0, 4'h2, 2'b00, 32'hA000_7777, 4'h0};
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        // Out of reset: nothing outstanding, W blocked, AW/AR open.
        cpu_axi_wvalid = 1; #1;
        check("reset_w_gate", W'({memory_axi_wvalid, cpu_axi_wready}), W'(2'b00));
        check("reset_aw_ar_ready", W'({cpu_axi_awready, cpu_axi_arready}), W'(2'b11));
        check("reset_b_r_valid", W'({cpu_axi_bvalid, cpu_axi_rvalid}), W'(2'b00));
        cpu_axi_wvalid = 0;
        @(negedge clk);

        for (int i = 0; i < 18; i++) begin
            if (vecs[i].wr)
                do_write(vecs[i].addr, vecs[i].lock, vecs[i].data, vecs[i].strb, vecs[i].id,
                         vecs[i].exp_resp, vecs[i].exp_strb);
            else
                do_read(vecs[i].addr, vecs[i].lock, 8'd0, vecs[i].id, vecs[i].exp_resp,
                        vecs[i].exp_rdata, 32'h0);
        end

        // Same-cycle AW and AR: the write checks the old reservation, and the
        // exclusive read re-arms it.
        do_read(32'h14, 1'b1, 8'd0, 4'h3, 2'b01, 32'hA000_0005, 32'h0);
        fork
            do_write(32'h14, 1'b1, 32'h1111_1111, 4'hF, 4'h4, 2'b01, 4'hF);
            do_read(32'h14, 1'b1, 8'd0, 4'h5, 2'b01, 32'hA000_0005, 32'h0);
        join
        do_write(32'h14, 1'b1, 32'h2222_2222, 4'hF, 4'h6, 2'b01, 4'hF);
        do_read(32'h14, 1'b0, 8'd0, 4'h7, 2'b00, 32'h2222_2222, 32'h0);

        // Exclusive read issued while a write is still outstanding.
        fork
            do_write(32'h04, 1'b0, 32'h3333_3333, 4'hF, 4'h8, 2'b00, 4'hF);
            begin
                @(negedge clk);
                @(negedge clk);
                do_read(32'h1C, 1'b1, 8'd0, 4'h9, 2'b01, 32'hA000_0007, 32'h0);
            end
        join
        do_write(32'h1C, 1'b1, 32'h4444_4444, 4'hF, 4'hA, 2'b01, 4'hF);

        // A locked burst is an ordinary read and leaves no reservation.
        do_read(32'h00, 1'b1, 8'd1, 4'hB, 2'b00, 32'hA000_0000, 32'h3333_3333);
        do_write(32'h00, 1'b1, 32'h5555_5555, 4'hF, 4'hC, 2'b00, 4'h0);

        // Reset with a write outstanding drops the reservation and busy state.
        do_read(32'h08, 1'b1, 8'd0, 4'hD, 2'b01, 32'hA000_0002, 32'h0);
        cpu_axi_awvalid = 1; cpu_axi_awaddr = 32'h08; cpu_axi_awlock = 1; cpu_axi_awid = 4'hE;
        n = 0; #1;
        while (!cpu_axi_awready && n < 50) begin @(negedge clk); #1; n++; end
        if (!cpu_axi_awready) fail_now("aw_timeout_rst");
        @(negedge clk);
        cpu_axi_awvalid = 0; cpu_axi_awlock = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        cpu_axi_wvalid = 1; #1;
        check("post_reset_w_gate", W'({memory_axi_wvalid, cpu_axi_wready}), W'(2'b00));
        cpu_axi_wvalid = 0;
        @(negedge clk);
        do_write(32'h08, 1'b1, 32'h6666_6666, 4'hF, 4'hF, 2'b00, 4'h0);
        do_read(32'h08, 1'b0, 8'd0, 4'h1, 2'b00, 32'hA000_0002, 32'h0);

        check("r_queue_empty", W'(exp_r_q.size()), W'(0));
        check("b_queue_empty", W'(exp_b_q.size()), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
